disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit display. It sits directly upstream of the 2-to-4 decoder.
- Drives the decoder's 2-bit select and enable so exactly one digit strobe is active at a time.
- Presents the selected digit's nibble and decimal point for the downstream seven-segment encoder.
- Inserts a blanking gap between digits to prevent ghosting.

Parameters:
- DIV, 1000, cycles each digit stays lit (SHOW length); legal range 1..2^CNT_W-1.
- BLANK_CYC, 4, cycles of all-off gap between digits; 0 means no BLANK state.
- CNT_W, 16, width of the internal cycle counter; must hold max(DIV, BLANK_CYC).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  scanning runs while high.
- digits  input  16  four BCD/hex nibbles; digit k = digits[4k+3:4k].
- dp_in  input  4  decimal-point request per digit; bit k belongs to digit k.
- sel  output  2  digit index, drives decoder input i.
- sel_en  output  1  drives decoder en; high only in SHOW.
- nibble  output  4  latched value of the currently selected digit.
- dp  output  1  latched dp_in[sel].
- frame_done  output  1  one-cycle pulse at each completed 4-digit frame.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, async) forces: state=IDLE, sel=0, sel_en=0, nibble=0, dp=0, frame_done=0, counter=0. Reset asserted mid-scan takes effect immediately with no completion of the current digit.
- States are IDLE, SHOW and BLANK.
- IDLE:
  - sel=0, sel_en=0.
  - On an edge with enable=1, go to SHOW with sel=0, counter=0, and latch nibble=digits[3:0], dp=dp_in[0].
  - Latency: sel_en is high in the cycle after enable is first sampled high.
- SHOW:
  - sel_en=1; counter increments each cycle.
  - When counter==DIV-1: counter=0, then go to BLANK. If BLANK_CYC==0, go straight to the next digit's SHOW instead.
- BLANK:
  - sel_en=0; sel and nibble hold; counter increments.
  - When counter==BLANK_CYC-1: counter=0, sel=sel+1 mod 4, latch nibble/dp for the new sel, enter SHOW.
- Data sampling:
  - digits and dp_in are sampled only on SHOW entry.
  - Changes mid-digit are not visible until that digit is next entered.
- Wrap: sel goes 3→0 with no extra cycle. Digit period = DIV+BLANK_CYC cycles; frame = 4·(DIV+BLANK_CYC) cycles.
- frame_done:
  - High for exactly the first SHOW cycle of digit 0 following a 3→0 wrap.
  - Not asserted on the initial entry from IDLE.
- enable deasserted in SHOW or BLANK:
  - Next edge: state=IDLE, sel=0, sel_en=0, counter=0. nibble/dp hold their last value; frame_done=0.
  - Re-enable restarts at digit 0.
- enable high during reset: ignored until rst_n releases. The first edge after release with enable=1 enters SHOW.
- Invariant: sel_en=1 only in SHOW, so at most one decoder output is ever active, and none during BLANK or IDLE.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - On SHOW entry for digit k (k=1..3), sel_en is held 0 for that whole SHOW period if digit k and every higher digit are 0 and dp_in for those digits is 0.
  - Digit 0 is always shown.
  - Timing, sel sequence and frame_done are unchanged.
- Undefined: all four digits are lit in every frame.

Test Plan:
- Reset and idle. Stimulus: rst_n=0 mid-SHOW of digit 2 (DIV=4, BLANK_CYC=2), then release with enable=0. Required: sel=0, sel_en=0, nibble=0, dp=0 immediately, and they stay 0.
- Basic scan. Stimulus: DIV=4, BLANK_CYC=2, digits=16'h4321, dp_in=4'b0100, enable=1. Required:
  - sel sequence 0,1,2,3; sel_en high 4 cycles then low 2 cycles per digit.
  - nibble=1,2,3,4; dp=1 only while sel=2.
  - frame_done pulses once, 24 cycles after the first SHOW, with sel=0.
- No blanking. Stimulus: BLANK_CYC=0, DIV=3. Required: sel_en continuously high after the first cycle; sel changes every 3 cycles; period 12 cycles.
- Mid-digit data change. Stimulus: change digits[7:4] from 2 to 9 during the SHOW of sel=1. Required: nibble stays 2 until the next frame's sel=1, where it shows 9.
- Enable drop and restart. Stimulus: enable=0 during the BLANK after sel=2, then enable=1 five cycles later. Required:
  - IDLE with sel_en=0 one cycle after the drop.
  - Restart at sel=0; no frame_done on the restart.
- LEADING_ZERO_BLANK_EN defined. Stimulus: digits=16'h0050, dp_in=0. Required: sel_en stays 0 during the SHOW periods of sel=2 and sel=3, and is high for sel=0 (nibble=0) and sel=1 (nibble=5).

Source files
------------

// File: rtl/disp_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_if
// Purpose  : Digit data in / decoder drive out bundle for disp_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface disp_scan_if;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [1:0]  sel;
    logic        sel_en;
    logic [3:0]  nibble;
    logic        dp;
    logic        frame_done;

    modport master (
        output enable, digits, dp_in,
        input  sel, sel_en, nibble, dp, frame_done
    );

    modport slave (
        input  enable, digits, dp_in,
        output sel, sel_en, nibble, dp, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : 4-digit time-multiplexed display scanner with inter-digit blanking.
//            Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    disp_scan_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_div_last   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYC - 1);
    localparam bit               c_has_blank  = (BLANK_CYC != 0);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic             r_sel_en, w_sel_en_nxt;
    logic [3:0]       r_nibble, w_nibble_nxt;
    logic             r_dp, w_dp_nxt;
    logic             r_frame_done, w_frame_done_nxt;

    logic             w_enter;
    logic [1:0]       w_enter_idx;
    logic [3:0]       w_lit;

    // A digit is lit unless it and every digit above it is blank (zero, no dp).
    always_comb begin
        w_lit = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 1; k < 4; k++) begin
            w_lit[k] = ((bus.digits >> (4 * k)) != 16'd0) ||
                       ((bus.dp_in >> k) != 4'd0);
        end
`endif
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sel_nxt        = r_sel;
        w_sel_en_nxt     = r_sel_en;
        w_nibble_nxt     = r_nibble;
        w_dp_nxt         = r_dp;
        w_frame_done_nxt = 1'b0;
        w_enter          = 1'b0;
        w_enter_idx      = r_sel + 2'd1;

        case (r_state)
            S_IDLE: begin
                if (bus.enable) begin
                    w_enter     = 1'b1;
                    w_enter_idx = 2'd0;
                end
            end
            S_SHOW: begin
                if (r_cnt == c_div_last) begin
                    w_cnt_nxt = '0;
                    if (c_has_blank) begin
                        w_state_nxt  = S_BLANK;
                        w_sel_en_nxt = 1'b0;
                    end else begin
                        w_enter = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_cnt_nxt = '0;
                    w_enter   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Digit data is sampled only here, on SHOW entry.
        if (w_enter) begin
            w_state_nxt      = S_SHOW;
            w_cnt_nxt        = '0;
            w_sel_nxt        = w_enter_idx;
            w_nibble_nxt     = bus.digits[{w_enter_idx, 2'b00} +: 4];
            w_dp_nxt         = bus.dp_in[w_enter_idx];
            w_sel_en_nxt     = w_lit[w_enter_idx];
            w_frame_done_nxt = (r_state != S_IDLE) && (w_enter_idx == 2'd0);
        end

        // Dropping enable abandons the scan; nibble/dp keep their last value.
        if ((r_state != S_IDLE) && !bus.enable) begin
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = '0;
            w_sel_nxt        = 2'd0;
            w_sel_en_nxt     = 1'b0;
            w_nibble_nxt     = r_nibble;
            w_dp_nxt         = r_dp;
            w_frame_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sel        <= 2'd0;
            r_sel_en     <= 1'b0;
            r_nibble     <= 4'd0;
            r_dp         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_sel_en     <= w_sel_en_nxt;
            r_nibble     <= w_nibble_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign bus.sel        = r_sel;
    assign bus.sel_en     = r_sel_en;
    assign bus.nibble     = r_nibble;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Purpose  : Self-checking bench for disp_scan_ctrl (blanking and no-blanking
//            instances) against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit c_lz = 1'b1;
`else
    localparam bit c_lz = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_en = 1'b0;
    logic [15:0] r_digits = 16'd0;
    logic [3:0]  r_dp_in = 4'd0;

    int n_pass = 0;
    int n_total = 0;

    disp_scan_if if_a ();
    disp_scan_if if_b ();

    assign if_a.enable = r_en;
    assign if_a.digits = r_digits;
    assign if_a.dp_in  = r_dp_in;
    assign if_b.enable = r_en;
    assign if_b.digits = r_digits;
    assign if_b.dp_in  = r_dp_in;

    disp_scan_ctrl #(.DIV(4), .BLANK_CYC(2), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    disp_scan_ctrl #(.DIV(3), .BLANK_CYC(0), .CNT_W(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the frame is derived from the number of
    // cycles since the scan started, using the digit period DIV+BLANK_CYC.
    int          c_div[2] = '{4, 3};
    int          c_blk[2] = '{2, 0};
    bit          m_run[2];
    int          m_t[2];
    logic [3:0]  m_nib[2];
    logic        m_dp[2];
    bit          m_lit[2];

    function automatic bit lit_of(int d, logic [15:0] dig, logic [3:0] dpi);
        if (!c_lz || d == 0) return 1'b1;
        return ((dig >> (4 * d)) != 16'd0) || ((dpi >> d) != 4'd0);
    endfunction

    function automatic void model_reset(int i);
        m_run[i] = 1'b0; m_t[i] = 0; m_nib[i] = 4'd0; m_dp[i] = 1'b0; m_lit[i] = 1'b0;
    endfunction

    function automatic void model_latch(int i, int d);
        m_nib[i] = r_digits[4*d +: 4];
        m_dp[i]  = r_dp_in[d];
        m_lit[i] = lit_of(d, r_digits, r_dp_in);
    endfunction

    function automatic void model_edge(int i);
        int per;
        int p;
        per = c_div[i] + c_blk[i];
        if (!rst_n) model_reset(i);
        else if (!m_run[i]) begin
            if (r_en) begin
                m_run[i] = 1'b1; m_t[i] = 0; model_latch(i, 0);
            end
        end else if (!r_en) m_run[i] = 1'b0;
        else begin
            m_t[i] = m_t[i] + 1;
            p = m_t[i] % (4 * per);
            if (p % per == 0) model_latch(i, p / per);
        end
    endfunction

    function automatic logic [8:0] model_out(int i);
        int per;
        int p;
        int d;
        int w;
        if (!m_run[i]) return {2'b00, 1'b0, m_nib[i], m_dp[i], 1'b0};
        per = c_div[i] + c_blk[i];
        p = m_t[i] % (4 * per);
        d = p / per;
        w = p % per;
        return {2'(d), (w < c_div[i]) && m_lit[i], m_nib[i], m_dp[i],
                (w == 0) && (d == 0) && (m_t[i] > 0)};
    endfunction

    function automatic logic [8:0] pk(logic [1:0] s, logic e, logic [3:0] n, logic d, logic f);
        return {s, e, n, d, f};
    endfunction

    function automatic logic [8:0] act_a();
        return {if_a.sel, if_a.sel_en, if_a.nibble, if_a.dp, if_a.frame_done};
    endfunction

    function automatic logic [8:0] act_b();
        return {if_b.sel, if_b.sel_en, if_b.nibble, if_b.dp, if_b.frame_done};
    endfunction

    task automatic check(string name, logic [8:0] act, logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: sel,en,nib,dp,fd got %b required %b", name, $time, act, exp);
    endtask

    task automatic check_int(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("model_a", act_a(), model_out(0));
        check("model_b", act_b(), model_out(1));
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check("async_rst_a", act_a(), pk(2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
        check("async_rst_b", act_b(), pk(2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    endtask

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] digits;
        logic [3:0]  dpi;
        int          ncyc;
        logic [8:0]  exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int run_ok;
        tbl[0] = '{1'b0, 1'b0, 16'h4321, 4'b0100, 1, pk(2'd0, 1'b0, 4'd0, 1'b0, 1'b0)};
        tbl[1] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 1, pk(2'd0, 1'b1, 4'd1, 1'b0, 1'b0)};
        tbl[2] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 3, pk(2'd0, 1'b1, 4'd1, 1'b0, 1'b0)};
        tbl[3] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 1, pk(2'd0, 1'b0, 4'd1, 1'b0, 1'b0)};
        tbl[4] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 2, pk(2'd1, 1'b1, 4'd2, 1'b0, 1'b0)};
        tbl[5] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 6, pk(2'd2, 1'b1, 4'd3, 1'b1, 1'b0)};
        tbl[6] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 4, pk(2'd2, 1'b0, 4'd3, 1'b1, 1'b0)};
        tbl[7] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 2, pk(2'd3, 1'b1, 4'd4, 1'b0, 1'b0)};
        tbl[8] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 6, pk(2'd0, 1'b1, 4'd1, 1'b0, 1'b1)};
        tbl[9] = '{1'b1, 1'b1, 16'h4321, 4'b0100, 1, pk(2'd0, 1'b1, 4'd1, 1'b0, 1'b0)};

        model_reset(0);
        model_reset(1);

        // Basic scan of 16'h4321 on the DIV=4/BLANK_CYC=2 instance
        for (int v = 0; v < 10; v++) begin
            rst_n    = tbl[v].rst_n;
            r_en     = tbl[v].en;
            r_digits = tbl[v].digits;
            r_dp_in  = tbl[v].dpi;
            repeat (tbl[v].ncyc) step();
            check($sformatf("table[%0d]", v), act_a(), tbl[v].exp);
        end

        // Mid-digit change of digit 1 (t=25 now)
        repeat (6) step();
        check("mid_before", act_a(), pk(2'd1, 1'b1, 4'd2, 1'b0, 1'b0));
        r_digits = 16'h4391;
        repeat (4) step();
        check("mid_hold", act_a(), pk(2'd1, 1'b0, 4'd2, 1'b0, 1'b0));
        repeat (19) step();
        check("mid_next_frame", act_a(), pk(2'd1, 1'b1, 4'd9, 1'b0, 1'b0));

        // Enable drop in the BLANK after digit 2, restart five cycles later
        repeat (10) step();
        check("blank_after_2", act_a(), pk(2'd2, 1'b0, 4'd3, 1'b1, 1'b0));
        r_en = 1'b0;
        step();
        check("idle_after_drop", act_a(), pk(2'd0, 1'b0, 4'd3, 1'b1, 1'b0));
        repeat (4) step();
        check("idle_hold", act_a(), pk(2'd0, 1'b0, 4'd3, 1'b1, 1'b0));
        r_en = 1'b1;
        step();
        check("restart", act_a(), pk(2'd0, 1'b1, 4'd1, 1'b0, 1'b0));

        // Reset in the middle of digit 2 SHOW, enable held high during reset
        repeat (13) step();
        check("show_2_pre_rst", act_a(), pk(2'd2, 1'b1, 4'd3, 1'b1, 1'b0));
        async_reset();
        step();
        r_en  = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        check("rst_release_idle", act_a(), pk(2'd0, 1'b0, 4'd0, 1'b0, 1'b0));

        // No-blanking instance: continuous sel_en, digit changes every 3 cycles
        r_digits = 16'h4321;
        r_en     = 1'b1;
        run_ok   = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (if_b.sel_en === 1'b1 && if_b.sel === 2'((k / 3) % 4)) run_ok++;
        end
        check_int("noblank_period", run_ok, 12);
        step();
        check("noblank_wrap", act_b(), pk(2'd0, 1'b1, 4'd1, 1'b0, 1'b1));

        // Leading zeros: 16'h0050
        r_en = 1'b0;
        step();
        r_digits = 16'h0050;
        r_dp_in  = 4'b0000;
        r_en     = 1'b1;
        step();
        check("lz_digit0", act_a(), pk(2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
        repeat (6) step();
        check("lz_digit1", act_a(), pk(2'd1, 1'b1, 4'd5, 1'b0, 1'b0));
        repeat (6) step();
        check("lz_digit2", act_a(), pk(2'd2, !c_lz, 4'd0, 1'b0, 1'b0));
        repeat (6) step();
        check("lz_digit3", act_a(), pk(2'd3, !c_lz, 4'd0, 1'b0, 1'b0));
        repeat (6) step();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 3))
                0: mask = 16'h000F;
                1: mask = 16'h00FF;
                2: mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            r_en = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 7) == 0) begin
                r_digits = 16'($urandom) & mask;
                r_dp_in  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
